// File: rtl/resource_arbiter.sv
// Round-robin front end sharing one registered lookup resource among NUM_REQ requesters.
// One request in flight at a time: accept -> issue -> capture -> respond.
module resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [31:0]             resource_input,
  input  logic [31:0]             resource_output
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] rr_idx;
  logic            found;
  logic [31:0]     win_addr;

  // Search starts just after the previous winner and wraps, so every holder is reached.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = ID_W'((32'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_addr = req_addr[i*32 +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NUM_REQ'(1) << winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= ID_W'(NUM_REQ - 1);
      cur_id         <= '0;
      resource_input <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      rsp_valid      <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            cur_id         <= winner;
            last_grant     <= winner;
            resource_input <= win_addr;
          end
        end
        ISSUE: resource_input <= '0;
        CAPTURE: begin
          rsp_data  <= resource_output;
          rsp_err   <= (resource_output == 32'hFFFF_FFFF);
          rsp_valid <= NUM_REQ'(1) << cur_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// Bench for resource_arbiter: directed stimulus, a latency/round-robin reference model
// checked every cycle, and hand-computed literal expectations.
module tb_resource_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [31:0]     resource_input;
  logic [31:0]     resource_output;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  resource_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .resource_input(resource_input),
    .resource_output(resource_output)
  );

  // Shared lookup resource: registered table, unmapped keys return all ones.
  function automatic logic [31:0] lookup(input logic [31:0] k);
    if (k == 0 || k > 32) return 32'hFFFF_FFFF;
    case (k)
      1:  return 32'd92;
      2:  return 32'd48;
      7:  return 32'd86;
      13: return 32'd6;
      14: return 32'd77;
      23: return 32'd91;
      31: return 32'd97;
      default: return k * 3 + 100;
    endcase
  endfunction

  always @(posedge clk) resource_output <= lookup(resource_input);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an accept at cycle t implies key on the bus at t+1,
  // response at t+3, and the next arbitration no earlier than t+4.
  int          cyc = 0;
  bit          started = 0;
  bit          active = 0;
  int          t_acc = 0;
  int          m_w = 0;
  int          m_lg = N - 1;
  logic [31:0] m_key = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    int d;
    int win;
    int j;
    bit busy_e;
    logic [N-1:0] rdy_e;
    logic [N-1:0] rv_e;
    logic [31:0]  ri_e;
    cyc++;
    d = active ? cyc - t_acc : 0;
    busy_e = active && d >= 1 && d <= 3;
    if (active && d == 3) begin
      m_data = lookup(m_key);
      m_err  = (m_data == 32'hFFFF_FFFF);
    end
    win = -1;
    rdy_e = '0;
    if (!busy_e) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_lg + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    if (win >= 0) rdy_e[win] = 1'b1;
    ri_e = (active && d == 1) ? m_key : 32'd0;
    rv_e = '0;
    if (active && d == 3) rv_e[m_w] = 1'b1;
    if (started) begin
      check("m_ready", 32'(req_ready), 32'(rdy_e));
      check("m_busy", 32'(busy), 32'(busy_e));
      check("m_resin", resource_input, ri_e);
      check("m_rspv", 32'(rsp_valid), 32'(rv_e));
      check("m_data", rsp_data, m_data);
      check("m_err", 32'(rsp_err), 32'(m_err));
    end
    if (reset) begin
      started = 1;
      active  = 0;
      m_lg    = N - 1;
      m_data  = '0;
      m_err   = 1'b0;
    end else if (win >= 0) begin
      active = 1;
      t_acc  = cyc;
      m_w    = win;
      m_key  = req_addr[win*32 +: 32];
      m_lg   = win;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    reset = 1'b1;
    req_valid = '0;
    drive_edge();
    drive_edge();
    reset = 1'b0;
  endtask

  task automatic set_addr(input int id, input logic [31:0] key);
    req_addr[id*32 +: 32] = key;
  endtask

  // Returns at the falling edge of the accept cycle (ok=1) or after the bound expires.
  task automatic wait_ready(input int id, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1;
        break;
      end
      drive_edge();
    end
    if (!ok) check("accept_wait", 32'd0, 32'd1);
  endtask

  task automatic serve_one(input int id, input logic [31:0] key,
                           input logic [31:0] exp_data, input logic exp_err);
    bit ok;
    drive_edge();
    set_addr(id, key);
    req_valid[id] = 1'b1;
    wait_ready(id, ok);
    if (!ok) begin
      req_valid[id] = 1'b0;
      return;
    end
    check("ready_onehot", 32'(req_ready), 32'(1 << id));
    drive_edge();
    req_valid[id] = 1'b0;
    @(negedge clk);
    check("issue_key", resource_input, key);
    check("issue_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(1 << id));
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [31:0] keys [3];
    logic [31:0] exps [3];

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_resin", resource_input, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single request and unmapped keys
    serve_one(1, 32'd1, 32'd92, 1'b0);
    serve_one(3, 32'd0, 32'hFFFF_FFFF, 1'b1);
    serve_one(1, 32'd40, 32'hFFFF_FFFF, 1'b1);

    // Two simultaneous requesters after reset
    do_reset();
    set_addr(0, 32'd2);
    set_addr(2, 32'd31);
    req_valid = 4'b0101;
    wait_ready(0, ok);
    if (ok) begin
      check("pair_first", 32'(req_ready), 32'h1);
      drive_edge();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("pair_hold", 32'(req_ready), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("pair_rspv0", 32'(rsp_valid), 32'h1);
      check("pair_data0", rsp_data, 32'd48);
      @(negedge clk);
      check("pair_second", 32'(req_ready), 32'h4);
      drive_edge();
      req_valid[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pair_rspv2", 32'(rsp_valid), 32'h4);
      check("pair_data2", rsp_data, 32'd97);
    end

    // All four requesters held for 16 accepts
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, 32'(i + 3));
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      wait_ready(k % N, ok);
      if (!ok) break;
      check("rr_order", 32'(req_ready), 32'(1 << (k % N)));
    end
    drive_edge();
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Reset during CAPTURE
    drive_edge();
    set_addr(1, 32'd5);
    req_valid[1] = 1'b1;
    wait_ready(1, ok);
    drive_edge();
    req_valid[1] = 1'b0;
    drive_edge();
    reset = 1'b1;
    @(negedge clk);
    check("cap_busy", 32'(busy), 32'd1);
    check("cap_rspv", 32'(rsp_valid), 32'd0);
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rspv", 32'(rsp_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_data", rsp_data, 32'd0);
    check("post_rst_err", 32'(rsp_err), 32'd0);
    check("post_rst_resin", resource_input, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(rsp_valid), 32'd0);
    end
    serve_one(2, 32'd14, 32'd77, 1'b0);

    // Back-to-back from requester 0 with req_valid held
    keys[0] = 32'd7;  keys[1] = 32'd23; keys[2] = 32'd13;
    exps[0] = 32'd86; exps[1] = 32'd91; exps[2] = 32'd6;
    drive_edge();
    set_addr(0, keys[0]);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    if (ok) begin
      for (int j = 0; j < 3; j++) begin
        check("b2b_accept", 32'(req_ready), 32'h1);
        drive_edge();
        if (j < 2) set_addr(0, keys[j+1]);
        else req_valid[0] = 1'b0;
        @(negedge clk);
        check("b2b_noready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("b2b_noready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("b2b_rspv", 32'(rsp_valid), 32'h1);
        check("b2b_data", rsp_data, exps[j]);
        if (j < 2) @(negedge clk);
      end
    end
    req_valid = '0;
    repeat (3) drive_edge();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
